// File: rtl/alu_pipe.sv
// EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops register in one edge; MUL is a WIDTH-step shift-add that stalls input.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ALUControl,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shiftAmount,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               overFlow,
    output logic               illegal_op
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLL  = 5'd4,
        OP_SRL  = 5'd5,
        OP_SRA  = 5'd6,
        OP_SGT  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_XOR  = 5'd10,
        OP_NOR  = 5'd11,
        OP_MUL  = 5'd12
    } op_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_ill;
    logic [WIDTH-1:0]   acc_step;
    logic               last_step;
    logic               accept;

    assign in_ready   = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign ALUResult  = result_q;
    assign overFlow   = ovf_q;
    assign illegal_op = ill_q;

    // Overflow is judged on this cycle's sum/difference, never on the stored result.
    assign sum  = data1 + data2;
    assign diff = data1 - data2;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_SLL:  alu_res = data1 << shiftAmount;
            OP_SRL:  alu_res = data1 >> shiftAmount;
            OP_SRA:  alu_res = $signed(data1) >>> shiftAmount;
            OP_SGT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) > $signed(data2))};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_XOR:  alu_res = data1 ^ data2;
            OP_NOR:  alu_res = ~(data1 | data2);
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step: add multiplicand<<counter when that multiplier bit is set.
    assign acc_step  = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0);
    assign last_step = (cnt_q == SHAMT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = data1;
                        mplier_d = data2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        ovf_d       = alu_ovf;
                        ill_d       = alu_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_d    = acc_step;
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed plan items plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_pipe;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int MUL_LAT = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         ALUControl;
    logic [WIDTH-1:0]   data1;
    logic [WIDTH-1:0]   data2;
    logic [SHAMT_W-1:0] shiftAmount;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   ALUResult;
    logic               overFlow;
    logic               illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             ill;
    } exp_t;

    alu_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .data1      (data1),
        .data2      (data2),
        .shiftAmount(shiftAmount),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .overFlow   (overFlow),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: signed results computed in 64-bit and range-checked for overflow.
    function automatic exp_t model(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh);
        exp_t   e;
        longint sa, sb, s;
        longint maxv, minv;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = 64'sd2147483647;
        minv = -maxv - 1;
        e    = '0;
        s    = 0;
        case (op)
            5'd0: begin s = sa + sb; e.res = s[31:0]; e.ovf = (s > maxv) || (s < minv); end
            5'd1: begin s = sa - sb; e.res = s[31:0]; e.ovf = (s > maxv) || (s < minv); end
            5'd2: e.res = a & b;
            5'd3: e.res = a | b;
            5'd4: e.res = a << sh;
            5'd5: e.res = a >> sh;
            5'd6: begin s = sa >>> sh; e.res = s[31:0]; end
            5'd7: e.res = (sa > sb) ? 32'd1 : 32'd0;
            5'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
            5'd9: e.res = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            5'd10: e.res = a ^ b;
            5'd11: e.res = ~(a | b);
            5'd12: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one op and hold it until accepted; returns #1 after the acceptance edge.
    task automatic send(input logic [4:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh);
        int guard;
        guard       = 0;
        ALUControl  = op;
        data1       = a;
        data2       = b;
        shiftAmount = sh;
        in_valid    = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("send_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send, wait for the result (bounded for MUL), compare against the model.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh);
        exp_t e;
        int   cycles;
        e = model(op, a, b, sh);
        send(op, a, b, sh);
        if (op == 5'd12) begin
            cycles = 0;
            while (!out_valid && cycles < 2 * MUL_LAT) begin
                @(posedge clk); #1;
                cycles++;
            end
            check({tag, "_mul_latency"}, 64'(cycles), 64'(MUL_LAT));
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, 64'(ALUResult), 64'(e.res));
        check({tag, "_ovf"}, 64'(overFlow), 64'(e.ovf));
        check({tag, "_ill"}, 64'(illegal_op), 64'(e.ill));
    endtask

    initial begin
        logic [4:0]       op;
        logic [WIDTH-1:0] a, b;
        logic [SHAMT_W-1:0] sh;
        int               cycles;
        logic             ready_seen;
        logic             stale;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ALUControl  = '0;
        data1       = '0;
        data2       = '0;
        shiftAmount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(ALUResult), 64'd0);
        check("rst_ovf", 64'(overFlow), 64'd0);
        check("rst_ill", 64'(illegal_op), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Overflow and sign handling on ADD/SUB, then shifts and compares.
        run_op("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        check("add_ovf_res_const", 64'(ALUResult), 64'h80000000);
        run_op("add_small", 5'd0, 32'd5, 32'hFFFFFFFD, 5'd0);
        check("add_small_const", 64'(ALUResult), 64'd2);
        run_op("sub_minneg", 5'd1, 32'h00000000, 32'h80000000, 5'd0);
        check("sub_minneg_ovf_const", 64'(overFlow), 64'd1);
        run_op("sub_wrap", 5'd1, 32'h80000000, 32'h00000001, 5'd0);
        check("sub_wrap_const", 64'(ALUResult), 64'h7FFFFFFF);
        run_op("sra", 5'd6, 32'hF0000000, 32'd0, 5'd4);
        check("sra_const", 64'(ALUResult), 64'hFF000000);
        run_op("srl", 5'd5, 32'hF0000000, 32'd0, 5'd4);
        check("srl_const", 64'(ALUResult), 64'h0F000000);
        run_op("sll_zero", 5'd4, 32'h12345678, 32'd0, 5'd0);
        run_op("slt", 5'd8, 32'hFFFFFFFF, 32'd1, 5'd0);
        check("slt_const", 64'(ALUResult), 64'd1);
        run_op("sltu", 5'd9, 32'hFFFFFFFF, 32'd1, 5'd0);
        check("sltu_const", 64'(ALUResult), 64'd0);
        run_op("sgt", 5'd7, 32'd1, 32'hFFFFFFFF, 5'd0);

        // MUL with a second op offered during the run: never accepted.
        send(5'd12, 32'hFFFFFFFD, 32'd7, 5'd0);
        ALUControl = 5'd0;
        data1      = 32'd100;
        data2      = 32'd200;
        in_valid   = 1'b1;
        cycles     = 0;
        ready_seen = 1'b0;
        while (!out_valid && cycles < 2 * MUL_LAT) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        check("mul_busy_in_ready", 64'(ready_seen), 64'd0);
        check("mul_latency", 64'(cycles), 64'(MUL_LAT));
        check("mul_res", 64'(ALUResult), 64'hFFFFFFEB);
        check("mul_ovf", 64'(overFlow), 64'd0);
        @(posedge clk); #1;
        check("mul_no_second_accept", 64'(out_valid), 64'd0);

        // Backpressure hold, then same-edge drain and accept.
        out_ready = 1'b0;
        send(5'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_res", 64'(ALUResult), 64'h0000F000);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready   = 1'b1;
        ALUControl  = 5'd3;
        data1       = 32'h0000F0F0;
        data2       = 32'h0000FF00;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("drain_accept_valid", 64'(out_valid), 64'd1);
        check("drain_accept_res", 64'(ALUResult), 64'h0000FFF0);

        // Reset 10 cycles into a MUL: no partial product ever appears.
        send(5'd12, 32'h00001234, 32'h00005678, 5'd0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("mulrst_valid", 64'(out_valid), 64'd0);
        check("mulrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (2 * MUL_LAT) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("mulrst_no_stale", 64'(stale), 64'd0);
        check("mulrst_ready_after", 64'(in_ready), 64'd1);

        run_op("illegal20", 5'd20, 32'hDEADBEEF, 32'h12345678, 5'd3);
        check("illegal20_const", 64'(illegal_op), 64'd1);
        run_op("mul_after_rst", 5'd12, 32'h00010001, 32'h00000003, 5'd0);

        // Randomized ops, biased toward legal opcodes and boundary operands.
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'h80000000;
                2: a = 32'h7FFFFFFF;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op("rand", op, a, b, sh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the datapath ALU; sits in the EX stage of the pipeline.
- Accepts operations over a valid/ready input handshake and returns results over a valid/ready output handshake, so EX can stall.
- Single-cycle ops complete with one-register latency. MUL is an iterative multi-cycle op that blocks new input while it runs.
- Overflow is computed from the true sum of the current operation. Undefined opcodes are flagged.

Parameters:
- WIDTH, 32, operand/result width (>= 8, power of 2)
- SHAMT_W, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- ALUControl  in  5  opcode
- data1  in  WIDTH  operand A (signed)
- data2  in  WIDTH  operand B (signed)
- shiftAmount  in  SHAMT_W  shift count
- out_valid  out  1  result register holds unconsumed result
- out_ready  in  1  consumer takes result this cycle
- ALUResult  out  WIDTH  result
- overFlow  out  1  signed overflow (ADD/SUB only, else 0)
- illegal_op  out  1  opcode undefined (result 0)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, ALUResult=0, overFlow=0, illegal_op=0, iteration counter=0, multiplier accumulator=0.
- Opcodes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 SLL (data1<<shamt)
  - 5 SRL (logical)
  - 6 SRA (arithmetic)
  - 7 SGT (signed data1>data2 -> 1 else 0)
  - 8 SLT (signed data1<data2 -> 1 else 0)
  - 9 SLTU (unsigned less)
  - 10 XOR
  - 11 NOR
  - 12 MUL (low WIDTH bits of product)
  - 13-31 illegal.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready at a rising edge (acceptance edge E0).
  - Output transfer occurs when out_valid && out_ready.
- Single-cycle ops: the result, overFlow and illegal_op are registered on E0, and out_valid=1 after E0 (latency 1). Back-to-back accepts give one result per cycle when out_ready=1.
- Overflow:
  - ADD: set when data1[MSB]==data2[MSB] and sum[MSB]!=data1[MSB].
  - SUB: set when data1[MSB]!=data2[MSB] and diff[MSB]!=data1[MSB]. This covers data2 = most-negative value.
  - Overflow is evaluated on the sum/difference produced in the same cycle, not on the previous ALUResult.
- MUL state machine (states IDLE, MUL):
  - On E0 with opcode 12: latch operands, clear accumulator, counter=0, go to MUL.
  - In MUL, each edge performs one shift-add step (add multiplicand<<counter if multiplier bit[counter]) and increments the counter.
  - On the WIDTH-th edge after E0: load ALUResult=accumulator (mod 2^WIDTH), overFlow=0, illegal_op=0, set out_valid=1, return to IDLE.
  - in_ready=0 throughout MUL.
  - The output register is guaranteed free at completion, because acceptance required it free or draining.
- Backpressure: while out_valid && !out_ready, ALUResult/overFlow/illegal_op hold and in_ready=0. When out_ready=1 and no new accept, out_valid clears next edge.
- Simultaneous drain and accept: the output register reloads with the new result and out_valid stays 1.
- Shift counts: taken modulo WIDTH by port width. shamt=0 passes data1 unchanged.
- Illegal opcode: accepted like a single-cycle op, giving ALUResult=0, overFlow=0, illegal_op=1.
- Reset mid-MUL: aborts immediately, back to IDLE, out_valid=0. The partial product is discarded and never presented.
- in_valid dropping after acceptance has no effect. Inputs are sampled only at the acceptance edge.

Test Plan:
1. WIDTH=32, ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle ALUResult=0x80000000, overFlow=1, out_valid=1; then ADD 5+(-3) -> 2, overFlow=0.
2. SUB 0x00000000-0x80000000 -> 0x80000000, overFlow=1; SUB 0x80000000-1 -> 0x7FFFFFFF, overFlow=1.
3. SRA 0xF0000000 by 4 -> 0xFF000000; SRL same -> 0x0F000000; SLT -1,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
4. MUL 0xFFFFFFFD*7 -> 0xFFFFFFEB exactly 32 edges after acceptance; in_ready=0 for those 32 cycles; a second op offered during MUL is not accepted.
5. Hold out_ready=0 for 3 cycles after AND 0xF0F0,0xFF00 -> ALUResult=0xF000 stable, in_ready=0; raise out_ready with a new OR offered -> same-edge drain+accept, out_valid stays 1.
6. Assert rst 10 cycles into a MUL -> out_valid=0 and in_ready=1 after release with no stale result. Opcode 20 -> ALUResult=0, illegal_op=1.
